// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester-side and FIFO-write-side signals of the write arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_valid;
    logic                          fifo_full;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;
    logic [7:0]                    burst_cnt;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_data, fifo_valid, grant_id, busy, burst_cnt
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_data, fifo_valid, grant_id, busy, burst_cnt
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-limited sharing of one FIFO write port.
// Data passes through unregistered; only the grant, history and burst count are stored.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int ID_WIDTH   = 2
) (
    input logic clock,
    input logic rst,
    fifo_write_arbiter_if.master bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   pick;
    logic [7:0]            burst_cnt;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic                  busy;
    logic                  cur_valid;
    logic                  xfer;
    logic                  done;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[ID_WIDTH'((int'(last_grant) + k) % NUM_REQ)])
                pick = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
        end
    end

    assign busy      = state == GRANT;
    assign cur_valid = bus.req_valid[grant_id];
    assign xfer      = busy && cur_valid && !bus.fifo_full;
    assign done      = busy && (!cur_valid || (xfer && burst_cnt == 8'(MAX_BURST - 1)));

    assign bus.busy       = busy;
    assign bus.grant_id   = grant_id;
    assign bus.burst_cnt  = burst_cnt;
    assign bus.fifo_valid = busy && cur_valid;
    assign bus.fifo_data  = busy ? words[grant_id] : '0;
    assign bus.req_ready  = (busy && !bus.fifo_full) ? NUM_REQ'(1) << grant_id : '0;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else if (!busy) begin
            if (|bus.req_valid) begin
                state    <= GRANT;
                grant_id <= pick;
            end
        end else if (done) begin
            state      <= IDLE;
            last_grant <= grant_id;
            burst_cnt  <= '0;
        end else if (xfer) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table plus directed burst/stall/reset sequences and a random stress run.
module tb_fifo_write_arbiter;
    localparam int N = 4, DW = 32, MB = 8, IW = 2;
    localparam int WAIT_MAX = (N - 1) * (MB + 1) + 1;

    logic clock = 1'b0;
    logic rst = 1'b1;
    always #5 clock = ~clock;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();
    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_WIDTH(IW)) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [N-1:0]  v;
        logic          f;
        logic          b;
        logic [IW-1:0] g;
        logic [N-1:0]  r;
        logic          fv;
        logic [7:0]    c;
    } vec_t;

    vec_t tab[14];
    int passed = 0, total = 0;
    int head[N], len[N], fnext[N], waitc[N];
    logic [N-1:0] en, pops, vld, s_ready;
    logic full_m, push, prev_busy, s_busy;
    logic [DW-1:0] pdata;
    logic [7:0] s_cnt;
    int cur_len, cur_max, cyc, last_push, maxw, stall;
    int grants[$], lens[$], maxes[$];

    function automatic logic [DW-1:0] word(int i, int n);
        return {8'(i), 24'(32'h100 + n)};
    endfunction

    function automatic int qat(int q[$], int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = en[i] && head[i] < len[i];
            bus.req_data[i*DW +: DW] = word(i, head[i]);
        end
        bus.fifo_full = full_m;
    endtask

    // One clock: drive the requester model, score the FIFO side at negedge, retire pops at posedge.
    task automatic step();
        int src;
        drive();
        @(negedge clock);
        vld = bus.req_valid;
        pops = bus.req_ready & bus.req_valid;
        push = bus.fifo_valid && !bus.fifo_full;
        pdata = bus.fifo_data;
        s_busy = bus.busy;
        s_cnt = bus.burst_cnt;
        s_ready = bus.req_ready;
        chk("handshake", $countones(pops), 32'(push));
        if (push) begin
            src = int'(pdata[31:24]);
            if (src < N) begin
                chk("source", 32'(pops), 32'(N'(1) << src));
                chk("order", pdata, word(src, fnext[src]));
                fnext[src]++;
            end else begin
                chk("source id", src, 0);
            end
            last_push = cyc;
        end
        if (s_busy && !prev_busy) begin
            grants.push_back(int'(bus.grant_id));
            cur_len = 0;
            cur_max = 0;
        end
        if (s_busy) begin
            cur_len += int'(push);
            if (int'(s_cnt) > cur_max) cur_max = int'(s_cnt);
        end
        if (!s_busy && prev_busy) begin
            lens.push_back(cur_len);
            maxes.push_back(cur_max);
        end
        prev_busy = s_busy;
        @(posedge clock);
        for (int i = 0; i < N; i++) if (pops[i]) head[i]++;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = '0;
        full_m = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0; len[i] = 0; fnext[i] = 0; waitc[i] = 0;
        end
        grants.delete(); lens.delete(); maxes.delete();
        prev_busy = 1'b0;
        cyc = 0;
        last_push = -1;
        drive();
        @(posedge clock);
        @(posedge clock);
        #1 rst = 1'b0;
    endtask

    initial begin
        tab[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tab[1]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tab[2]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'd0};
        tab[3]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1, 8'd1};
        tab[4]  = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'd1};
        tab[5]  = '{4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 8'd2};
        tab[6]  = '{4'b0001, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 8'd0};
        tab[7]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'd0};
        tab[8]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 8'd1};
        tab[9]  = '{4'b1010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd0};
        tab[10] = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 8'd0};
        tab[11] = '{4'b1000, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 8'd0};
        tab[12] = '{4'b1000, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 8'd0};
        tab[13] = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'd0};

        do_reset();
        for (int k = 0; k < 14; k++) begin
            drive();
            bus.req_valid = tab[k].v;
            bus.fifo_full = tab[k].f;
            @(negedge clock);
            chk($sformatf("v%0d busy", k), 32'(bus.busy), 32'(tab[k].b));
            chk($sformatf("v%0d grant_id", k), 32'(bus.grant_id), 32'(tab[k].g));
            chk($sformatf("v%0d req_ready", k), 32'(bus.req_ready), 32'(tab[k].r));
            chk($sformatf("v%0d fifo_valid", k), 32'(bus.fifo_valid), 32'(tab[k].fv));
            chk($sformatf("v%0d burst_cnt", k), 32'(bus.burst_cnt), 32'(tab[k].c));
            chk($sformatf("v%0d fifo_data", k), bus.fifo_data, tab[k].b ? word(int'(tab[k].g), 0) : '0);
            @(posedge clock);
            #1;
        end

        // Lone requester 2 streaming 20 words: bursts 8,8,4 with one idle cycle between.
        do_reset();
        len[2] = 20;
        en = 4'b0100;
        repeat (26) step();
        chk("s1 bursts", lens.size(), 3);
        chk("s1 burst0", qat(lens, 0), 8);
        chk("s1 burst1", qat(lens, 1), 8);
        chk("s1 burst2", qat(lens, 2), 4);
        chk("s1 words", fnext[2], 20);
        chk("s1 last push cycle", last_push, 22);
        for (int i = 0; i < 3; i++) chk($sformatf("s1 grant%0d", i), qat(grants, i), 2);

        // All four continuously valid: order 0,1,2,3,0 with full bursts.
        do_reset();
        for (int i = 0; i < N; i++) len[i] = 100;
        en = 4'b1111;
        repeat (46) step();
        for (int i = 0; i < 5; i++) chk($sformatf("s2 grant%0d", i), qat(grants, i), i % N);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2 len%0d", i), qat(lens, i), MB);
            chk($sformatf("s2 maxcnt%0d", i), qat(maxes, i), MB - 1);
        end

        // Full for 5 cycles after the 3rd word.
        do_reset();
        len[0] = 20;
        en = 4'b0001;
        stall = 0;
        repeat (15) begin
            full_m = fnext[0] == 3 && stall < 5;
            step();
            if (full_m) begin
                stall++;
                chk("s3 stall cnt", 32'(s_cnt), 3);
                chk("s3 stall ready", 32'(s_ready), 0);
            end
        end
        chk("s3 stalls", stall, 5);
        chk("s3 len", qat(lens, 0), MB);
        chk("s3 words", fnext[0], MB);

        // Requester 1 gives up after 2 words; requester 3 waiting takes over.
        do_reset();
        len[1] = 2;
        len[3] = 20;
        en = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 3) begin
                chk("s4 exit busy", 32'(s_busy), 1);
                chk("s4 exit cnt", 32'(s_cnt), 2);
            end
        end
        chk("s4 grant0", qat(grants, 0), 1);
        chk("s4 len0", qat(lens, 0), 2);
        chk("s4 grant1", qat(grants, 1), 3);

        // Reset during the 5th word of a burst.
        do_reset();
        len[0] = 20;
        len[2] = 20;
        en = 4'b0001;
        repeat (5) step();
        drive();
        @(negedge clock);
        chk("s5 pre fvalid", 32'(bus.fifo_valid), 1);
        chk("s5 pre data", bus.fifo_data, word(0, 4));
        chk("s5 pre cnt", 32'(bus.burst_cnt), 4);
        rst = 1'b1;
        #1;
        chk("s5 rst busy", 32'(bus.busy), 0);
        chk("s5 rst ready", 32'(bus.req_ready), 0);
        chk("s5 rst fvalid", 32'(bus.fifo_valid), 0);
        chk("s5 rst cnt", 32'(bus.burst_cnt), 0);
        @(posedge clock);
        #1 rst = 1'b0;
        prev_busy = 1'b0;
        grants.delete();
        en = 4'b0101;
        repeat (3) step();
        chk("s5 first grant", qat(grants, 0), 0);
        chk("s5 resumed words", fnext[0], 6);

        // Random valid/full stress with per-requester scoreboard and wait bound.
        do_reset();
        for (int i = 0; i < N; i++) len[i] = 1 << 20;
        maxw = 0;
        repeat (1000) begin
            full_m = $urandom_range(0, 4) == 0;
            step();
            for (int i = 0; i < N; i++) begin
                if (pops[i]) begin
                    waitc[i] = 0;
                    en[i] = $urandom_range(0, 3) != 0;
                end else if (vld[i]) begin
                    if (!full_m) waitc[i]++;
                end else begin
                    en[i] = $urandom_range(0, 2) == 0;
                end
                if (waitc[i] > maxw) maxw = waitc[i];
            end
        end
        for (int i = 0; i < N; i++) chk($sformatf("s6 count%0d", i), fnext[i], head[i]);
        chk("s6 max wait", 32'(maxw <= WAIT_MAX), 1);
        chk("s6 traffic", 32'(fnext[0] + fnext[1] + fnext[2] + fnext[3] > 100), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
